// File: rtl/pipe_stage_regs_pkg.sv
// Shared types for the front-end pipeline registers: stage payload structs,
// the canonical NOP word and the ResultSrc encoding.
package pipe_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RESULT_SRC_ALU = 2'd0,
    RESULT_SRC_MEM = 2'd1,
    RESULT_SRC_PC4 = 2'd2
  } result_src_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_control;
    logic        alu_src;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } id_ex_t;

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Hazard commands, fetch/decode inputs and the registered stage outputs.
// master = hazard unit / datapath side, slave = the register bank.
interface pipe_stage_regs_if;
  logic        StallF, StallD, FlushD, FlushE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrF;

  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;

  logic [31:0] PCF, PCPlus4F;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ValidE;

  logic [31:0] StallCnt, FlushCnt;

  modport master (
    output StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF,
           RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD,
           ALUSrcD, RD1D, RD2D, Rs1D, Rs2D, RdD, ImmExtD,
    input  PCF, PCPlus4F, InstrD, PCD, PCPlus4D, ValidD,
           RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
           ALUSrcE, RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PCPlus4E,
           ValidE, StallCnt, FlushCnt
  );

  modport slave (
    input  StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF,
           RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD,
           ALUSrcD, RD1D, RD2D, Rs1D, Rs2D, RdD, ImmExtD,
    output PCF, PCPlus4F, InstrD, PCD, PCPlus4D, ValidD,
           RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
           ALUSrcE, RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PCPlus4E,
           ValidE, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipe_stage_regs_reg.sv
// Generic pipeline register: clear beats enable; reset and clear both load
// CLR_VALUE so a reset stage looks exactly like a flushed one.
module pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_q <= CLR_VALUE;
    else if (i_clr) r_q <= CLR_VALUE;
    else if (i_en)  r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX registers driven by hazard-unit stall/flush commands,
// plus stall/flush event counters for performance debug.
module pipe_stage_regs
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input logic              clk,
  input logic              rst_n,
  pipe_stage_regs_if.slave bus
);
  localparam if_id_t IF_ID_CLR = '{instr: NOP_INSTR, default: '0};
  localparam id_ex_t ID_EX_CLR = '{result_src: RESULT_SRC_ALU, default: '0};

  logic [31:0] w_pc, w_pc_plus4, w_pc_next;
  if_id_t      w_if_id_d, w_if_id_q;
  id_ex_t      w_id_ex_d, w_id_ex_q;
  logic [31:0] r_stall_cnt, r_flush_cnt;

  assign w_pc_plus4 = w_pc + 32'd4;
  // StallF with PCSrcE is illegal; the enable gate makes the stall win anyway.
  assign w_pc_next  = bus.PCSrcE ? bus.PCTargetE : w_pc_plus4;

  pipe_reg #(.WIDTH(32), .CLR_VALUE(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .i_en(~bus.StallF), .i_clr(1'b0),
    .i_d(w_pc_next), .o_q(w_pc)
  );

  always_comb begin
    w_if_id_d          = IF_ID_CLR;
    w_if_id_d.instr    = bus.InstrF;
    w_if_id_d.pc       = w_pc;
    w_if_id_d.pc_plus4 = w_pc_plus4;
    w_if_id_d.valid    = 1'b1;
  end

  pipe_reg #(.WIDTH($bits(if_id_t)), .CLR_VALUE(IF_ID_CLR)) u_if_id (
    .clk(clk), .rst_n(rst_n), .i_en(~bus.StallD), .i_clr(bus.FlushD),
    .i_d(w_if_id_d), .o_q(w_if_id_q)
  );

  always_comb begin
    w_id_ex_d             = ID_EX_CLR;
    w_id_ex_d.reg_write   = bus.RegWriteD;
    w_id_ex_d.result_src  = result_src_t'(bus.ResultSrcD);
    w_id_ex_d.mem_write   = bus.MemWriteD;
    w_id_ex_d.jump        = bus.JumpD;
    w_id_ex_d.branch      = bus.BranchD;
    w_id_ex_d.alu_control = bus.ALUControlD;
    w_id_ex_d.alu_src     = bus.ALUSrcD;
    w_id_ex_d.rd1         = bus.RD1D;
    w_id_ex_d.rd2         = bus.RD2D;
    w_id_ex_d.rs1         = bus.Rs1D;
    w_id_ex_d.rs2         = bus.Rs2D;
    w_id_ex_d.rd          = bus.RdD;
    w_id_ex_d.imm_ext     = bus.ImmExtD;
    w_id_ex_d.pc          = w_if_id_q.pc;
    w_id_ex_d.pc_plus4    = w_if_id_q.pc_plus4;
    w_id_ex_d.valid       = w_if_id_q.valid;
  end

  pipe_reg #(.WIDTH($bits(id_ex_t)), .CLR_VALUE(ID_EX_CLR)) u_id_ex (
    .clk(clk), .rst_n(rst_n), .i_en(1'b1), .i_clr(bus.FlushE),
    .i_d(w_id_ex_d), .o_q(w_id_ex_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.StallD && !bus.FlushD)  r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.FlushD || bus.FlushE)   r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.PCF         = w_pc;
  assign bus.PCPlus4F    = w_pc_plus4;
  assign bus.InstrD      = w_if_id_q.instr;
  assign bus.PCD         = w_if_id_q.pc;
  assign bus.PCPlus4D    = w_if_id_q.pc_plus4;
  assign bus.ValidD      = w_if_id_q.valid;
  assign bus.RegWriteE   = w_id_ex_q.reg_write;
  assign bus.ResultSrcE  = w_id_ex_q.result_src;
  assign bus.MemWriteE   = w_id_ex_q.mem_write;
  assign bus.JumpE       = w_id_ex_q.jump;
  assign bus.BranchE     = w_id_ex_q.branch;
  assign bus.ALUControlE = w_id_ex_q.alu_control;
  assign bus.ALUSrcE     = w_id_ex_q.alu_src;
  assign bus.RD1E        = w_id_ex_q.rd1;
  assign bus.RD2E        = w_id_ex_q.rd2;
  assign bus.Rs1E        = w_id_ex_q.rs1;
  assign bus.Rs2E        = w_id_ex_q.rs2;
  assign bus.RdE         = w_id_ex_q.rd;
  assign bus.ImmExtE     = w_id_ex_q.imm_ext;
  assign bus.PCE         = w_id_ex_q.pc;
  assign bus.PCPlus4E    = w_id_ex_q.pc_plus4;
  assign bus.ValidE      = w_id_ex_q.valid;
  assign bus.StallCnt    = r_stall_cnt;
  assign bus.FlushCnt    = r_flush_cnt;
endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: reset, fetch, stall, branch, conflict,
// counter wrap and asynchronous reset, with hand-computed expectations.
module tb_pipe_stage_regs;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pipe_stage_regs_if bus ();

  pipe_stage_regs #(.RESET_PC(32'h0), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmds(input logic sf, input logic sd, input logic fd, input logic fe,
                      input logic pcs, input logic [31:0] tgt);
    bus.StallF = sf; bus.StallD = sd; bus.FlushD = fd; bus.FlushE = fe;
    bus.PCSrcE = pcs; bus.PCTargetE = tgt;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    cmds(0, 0, 0, 0, 0, 32'h0);
    bus.InstrF      = 32'h0;
    bus.RegWriteD   = 1'b1;
    bus.ResultSrcD  = 2'd1;
    bus.MemWriteD   = 1'b0;
    bus.JumpD       = 1'b0;
    bus.BranchD     = 1'b1;
    bus.ALUControlD = 3'd5;
    bus.ALUSrcD     = 1'b1;
    bus.RD1D        = 32'h1111_1111;
    bus.RD2D        = 32'h2222_2222;
    bus.Rs1D        = 5'd3;
    bus.Rs2D        = 5'd4;
    bus.RdD         = 5'd5;
    bus.ImmExtD     = 32'h0000_0abc;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_pcf", bus.PCF, 32'h0);
    check("rst_pcplus4f", bus.PCPlus4F, 32'h4);
    check("rst_instrd", bus.InstrD, 32'h0000_0013);
    check("rst_validd", {31'b0, bus.ValidD}, 32'h0);
    check("rst_valide", {31'b0, bus.ValidE}, 32'h0);
    check("rst_stallcnt", bus.StallCnt, 32'h0);
    check("rst_flushcnt", bus.FlushCnt, 32'h0);

    // Straight-line fetch A, B, C, D.
    $display("txn fetch A at PC 0x0");
    bus.InstrF = 32'hAAAA_0001; step();
    check("fetch1_instrd", bus.InstrD, 32'hAAAA_0001);
    check("fetch1_pcd", bus.PCD, 32'h0);
    check("fetch1_pcplus4d", bus.PCPlus4D, 32'h4);
    check("fetch1_validd", {31'b0, bus.ValidD}, 32'h1);
    check("fetch1_pcf", bus.PCF, 32'h4);
    $display("txn fetch B at PC 0x4");
    bus.InstrF = 32'hBBBB_0002; step();
    check("fetch2_pce", bus.PCE, 32'h0);
    check("fetch2_pcplus4e", bus.PCPlus4E, 32'h4);
    check("fetch2_valide", {31'b0, bus.ValidE}, 32'h1);
    check("fetch2_rde", {27'b0, bus.RdE}, 32'h5);
    check("fetch2_rd1e", bus.RD1E, 32'h1111_1111);
    check("fetch2_aluctl", {29'b0, bus.ALUControlE}, 32'h5);
    check("fetch2_pcf", bus.PCF, 32'h8);
    $display("txn fetch C at PC 0x8");
    bus.InstrF = 32'hCCCC_0003; step();
    check("fetch3_pcf", bus.PCF, 32'hC);
    check("fetch3_pcplus4f", bus.PCPlus4F, 32'h10);
    check("fetch3_instrd", bus.InstrD, 32'hCCCC_0003);
    $display("txn fetch D at PC 0xC");
    bus.InstrF = 32'hDDDD_0004; step();
    check("fetch4_pcf", bus.PCF, 32'h10);

    // Load-use stall at PCF = 0x10.
    $display("txn load-use stall at PC 0x10");
    bus.InstrF = 32'hEEEE_0005;
    cmds(1, 1, 0, 1, 0, 32'h0); step();
    check("stall_pcf", bus.PCF, 32'h10);
    check("stall_instrd", bus.InstrD, 32'hDDDD_0004);
    check("stall_regwritee", {31'b0, bus.RegWriteE}, 32'h0);
    check("stall_rde", {27'b0, bus.RdE}, 32'h0);
    check("stall_rd1e", bus.RD1E, 32'h0);
    check("stall_valide", {31'b0, bus.ValidE}, 32'h0);
    check("stall_stallcnt", bus.StallCnt, 32'h1);
    check("stall_flushcnt", bus.FlushCnt, 32'h1);
    $display("txn release stall");
    cmds(0, 0, 0, 0, 0, 32'h0); step();
    check("unstall_pcf", bus.PCF, 32'h14);
    check("unstall_instrd", bus.InstrD, 32'hEEEE_0005);
    check("unstall_rde", {27'b0, bus.RdE}, 32'h5);
    check("unstall_pce", bus.PCE, 32'hC);

    // Taken branch to 0x100.
    $display("txn taken branch to 0x100");
    cmds(0, 0, 1, 1, 1, 32'h100); step();
    check("br_pcf", bus.PCF, 32'h100);
    check("br_validd", {31'b0, bus.ValidD}, 32'h0);
    check("br_valide", {31'b0, bus.ValidE}, 32'h0);
    check("br_instrd", bus.InstrD, 32'h0000_0013);
    check("br_pcd", bus.PCD, 32'h0);
    check("br_flushcnt", bus.FlushCnt, 32'h2);
    $display("txn fetch F at PC 0x100");
    cmds(0, 0, 0, 0, 0, 32'h0);
    bus.InstrF = 32'hFFFF_0006; step();
    check("postbr_pcd", bus.PCD, 32'h100);
    check("postbr_validd", {31'b0, bus.ValidD}, 32'h1);
    check("postbr_valide", {31'b0, bus.ValidE}, 32'h0);

    // StallD and FlushD together: flush wins, stall not counted.
    $display("txn StallD+FlushD conflict");
    cmds(0, 1, 1, 0, 0, 32'h0); step();
    check("conf_instrd", bus.InstrD, 32'h0000_0013);
    check("conf_validd", {31'b0, bus.ValidD}, 32'h0);
    check("conf_stallcnt", bus.StallCnt, 32'h1);
    check("conf_flushcnt", bus.FlushCnt, 32'h3);
    check("conf_pcf", bus.PCF, 32'h108);

    // Flush counter wrap from all-ones.
    $display("txn flush counter wrap");
    cmds(0, 0, 0, 0, 0, 32'h0);
    force dut.r_flush_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_flush_cnt;
    cmds(0, 0, 0, 1, 0, 32'h0); step();
    check("wrap_flushcnt", bus.FlushCnt, 32'h0);
    check("wrap_stallcnt", bus.StallCnt, 32'h1);
    check("wrap_pcf", bus.PCF, 32'h10C);

    // Illegal StallF with PCSrcE: PC holds.
    $display("txn StallF+PCSrcE hold");
    cmds(1, 0, 0, 0, 1, 32'h200); step();
    check("hold_pcf", bus.PCF, 32'h10C);

    // Branch to 0x40, then asynchronous reset between edges.
    $display("txn branch to 0x40 then async reset");
    cmds(0, 0, 0, 0, 1, 32'h40); step();
    check("pre_rst_pcf", bus.PCF, 32'h40);
    cmds(0, 0, 0, 0, 0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_pcf", bus.PCF, 32'h0);
    check("arst_instrd", bus.InstrD, 32'h0000_0013);
    check("arst_validd", {31'b0, bus.ValidD}, 32'h0);
    check("arst_valide", {31'b0, bus.ValidE}, 32'h0);
    check("arst_stallcnt", bus.StallCnt, 32'h0);
    check("arst_flushcnt", bus.FlushCnt, 32'h0);
    #1 rst_n = 1'b1;
    $display("txn resume after reset");
    step();
    check("resume_pcf", bus.PCF, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_regs.md
# pipe_stage_regs

Front-end pipeline register bank for the 5-stage RISC-V core: PC register, IF/ID register and ID/EX register, which carry out the stall and flush commands issued by the hazard unit. It sits between the fetch/decode datapath and the execute stage. It inserts bubbles (canonical NOP) on flush and holds state on stall. It also keeps stall and flush event counters for performance debug.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, `addi x0,x0,0` instruction word injected into the IF/ID register on flush

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- StallF, StallD, FlushD, FlushE  in  1 each  hazard-unit commands
- PCSrcE  in  1  taken branch or jump resolved in EX
- PCTargetE  in  32  branch or jump target
- InstrF  in  32  fetched instruction
- Decode bundle  in:
  - RegWriteD 1
  - ResultSrcD 2
  - MemWriteD 1
  - JumpD 1
  - BranchD 1
  - ALUControlD 3
  - ALUSrcD 1
  - RD1D 32
  - RD2D 32
  - Rs1D 5
  - Rs2D 5
  - RdD 5
  - ImmExtD 32
- PCF  out  32  current fetch PC
- PCPlus4F  out  32  PCF + 4, combinational
- InstrD, PCD, PCPlus4D  out  32 each  IF/ID contents
- ValidD  out  1  IF/ID holds a real instruction
- Execute bundle  out  same widths as the decode bundle with the E suffix, plus PCE 32, PCPlus4E 32 and ValidE 1
- StallCnt, FlushCnt  out  32 each  event counters

## Operation
- Next PC is PCTargetE when PCSrcE = 1, otherwise PCPlus4F.
- PC register:
  - StallF = 1: hold.
  - Otherwise: load the next PC.
- IF/ID register, priority FlushD > StallD > load:
  - Flush: InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0, ValidD = 0.
  - Stall: hold all fields.
  - Load: capture InstrF, PCF and PCPlus4F; ValidD = 1.
- ID/EX register, priority FlushE > load. It has no stall input.
  - Flush clears the control fields: RegWriteE, MemWriteE, JumpE and BranchE = 0; ResultSrcE = 0; ALUControlE = 0; ALUSrcE = 0.
  - Flush also sets RdE = 0, Rs1E = 0, Rs2E = 0 and ValidE = 0.
  - Flush sets the data fields (RD1E, RD2E, ImmExtE, PCE, PCPlus4E) to 0.
  - Load: capture the decode bundle, PCD and PCPlus4D; ValidE = ValidD.
- StallF = 1 together with PCSrcE = 1 is illegal input; if it occurs, the stall wins and the PC holds.
- StallD = 1 together with FlushD = 1: the flush wins.
- StallCnt increments each cycle in which StallD = 1 and FlushD = 0.
- FlushCnt increments each cycle in which FlushE = 1 or FlushD = 1, by 1 per cycle.
- Both counters wrap modulo 2^32.

## Timing
- Every command takes effect at the next rising edge of clk; register outputs change one cycle after the command.
- Latency is one cycle per stage: an instruction fetched at edge n appears in InstrD after edge n and in the E bundle after edge n+1.
- A load-use stall (StallF = StallD = FlushE = 1 for one cycle) has these effects:
  - One bubble in EX.
  - IF and ID each repeat their contents for one cycle.
- A taken branch (PCSrcE = FlushD = FlushE = 1) has these effects:
  - PCF = PCTargetE after the edge.
  - Two bubbles: the D and E stages are invalid in the following cycle.
- Reset, asynchronous on rst_n falling, in any cycle:
  - PCF = RESET_PC.
  - IF/ID in the flushed state.
  - ID/EX in the flushed state.
  - StallCnt = 0 and FlushCnt = 0.
  - Normal operation resumes at the first rising edge after rst_n rises.

## Structure
- Package `pipe_pkg` holds:
  - The `if_id_t` and `id_ex_t` packed structs.
  - The NOP constant, 32'h0000_0013.
  - The `RESULT_SRC_ALU/MEM/PC4` enum for ResultSrc.
- Sub-module `pipe_reg`: a generic WIDTH-bit register with en, clr and a CLR_VALUE parameter, asynchronous active-low reset to CLR_VALUE. It is instantiated once per stage on the packed structs.

## Test plan
- Reset mid-run: drive rst_n low while PCF = 0x40. Expected: PCF = 0x0, InstrD = 0x00000013, ValidD = ValidE = 0 and both counters = 0, with no clock edge required.
- Straight-line fetch: InstrF sequence A, B, C from PC 0. Expected: InstrD = A at cycle 1; PCE = 0 at cycle 2; PCF steps 0, 4, 8, 12.
- Load-use stall: one cycle of StallF, StallD and FlushE at PCF = 0x10. Expected:
  - PCF stays at 0x10 for two cycles.
  - InstrD is unchanged.
  - RegWriteE = 0 and RdE = 0 for one cycle.
  - StallCnt = 1.
- Taken branch: PCSrcE, FlushD and FlushE high with PCTargetE = 0x100. Expected: next PCF = 0x100; ValidD = 0 and ValidE = 0; FlushCnt = 1.
- Conflict: StallD = 1 and FlushD = 1 together. Expected: InstrD = NOP; StallCnt unchanged; FlushCnt + 1.
- Counter wrap: preload FlushCnt = 0xFFFFFFFF, then apply one flush. Expected: FlushCnt = 0.
